regfile_bank: RTL

Parametrised successor to the single 8-bit load register: a bank of NREGS registers of WIDTH bits. It has one write port with byte-lane strobes and two registered read ports with write-to-read bypass. It sits between the VeriRISC decode stage (operand addresses) and the ALU (operand data). It replaces the separate accumulator/operand registers.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_bank_if.sv | 34 +++
 rtl/regfile_rd_port.sv | 53 +++++
 rtl/regfile_bank.sv | 79 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-lane merge helper for the regfile_bank register file.
package regfile_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_NREGS = 8;

   // Words are handled at the maximum width (64) so that every WIDTH can share one helper.
   function automatic logic [63:0] lane_merge(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  strb);
      logic [63:0] merged;
      merged = old_word;
      for (int l = 0; l < 8; l++) begin
         if (strb[l]) begin
            merged[8*l +: 8] = new_word[8*l +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/regfile_bank_if.sv
// Write/read bus of regfile_bank: clear, one strobed write port and two read ports.
interface regfile_bank_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 8
);
   localparam int unsigned AW = $clog2(NREGS);

   logic               clr;
   logic               we;
   logic [AW-1:0]      waddr;
   logic [WIDTH-1:0]   wdata;
   logic [WIDTH/8-1:0] wstrb;
   logic               re_a;
   logic [AW-1:0]      raddr_a;
   logic [WIDTH-1:0]   rdata_a;
   logic               rvalid_a;
   logic               re_b;
   logic [AW-1:0]      raddr_b;
   logic [WIDTH-1:0]   rdata_b;
   logic               rvalid_b;

   modport master (
      output clr, we, waddr, wdata, wstrb,
      output re_a, raddr_a, re_b, raddr_b,
      input  rdata_a, rvalid_a, rdata_b, rvalid_b
   );

   modport slave (
      input  clr, we, waddr, wdata, wstrb,
      input  re_a, raddr_a, re_b, raddr_b,
      output rdata_a, rvalid_a, rdata_b, rvalid_b
   );

endinterface

// File: rtl/regfile_rd_port.sv
// Registered read port: clear/bypass/storage select in front of the data and valid flops.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clr,
   input  logic               i_re,
   input  logic [AW-1:0]      i_raddr,
   input  logic [WIDTH-1:0]   i_mem_data,
   input  logic               i_we,
   input  logic [AW-1:0]      i_waddr,
   input  logic [WIDTH-1:0]   i_wdata,
   input  logic [WIDTH/8-1:0] i_wstrb,
   output logic [WIDTH-1:0]   o_rdata,
   output logic               o_rvalid
);

   logic [WIDTH-1:0] r_rdata;
   logic             r_rvalid;
   logic             w_hit;
   logic [WIDTH-1:0] w_rdata_d;

   // A same-cycle write to the read address returns the post-write value.
   always_comb begin
      w_hit     = i_we && (i_waddr == i_raddr);
      w_rdata_d = i_mem_data;
      if (i_clr) begin
         w_rdata_d = '0;
      end else if (w_hit) begin
         w_rdata_d = WIDTH'(lane_merge(64'(i_mem_data), 64'(i_wdata), 8'(i_wstrb)));
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= i_re;
         if (i_re) begin
            r_rdata <= w_rdata_d;
         end
      end
   end

   assign o_rdata  = r_rdata;
   assign o_rvalid = r_rvalid;

endmodule

// File: rtl/regfile_bank.sv
// NREGS x WIDTH register bank with one byte-strobed write port and two bypassed read ports.
// Optional REGFILE_ZERO_REG_EN: register 0 reads as zero and ignores writes.
module regfile_bank
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned NREGS = DEF_NREGS
) (
   input logic           i_clk,
   input logic           i_rst_n,
   regfile_bank_if.slave bus
);

   localparam int unsigned AW = $clog2(NREGS);

   logic [WIDTH-1:0] r_mem [NREGS];
   logic             w_we_eff;
   logic [WIDTH-1:0] w_wr_word;
   logic [WIDTH-1:0] w_mem_a;
   logic [WIDTH-1:0] w_mem_b;

`ifdef REGFILE_ZERO_REG_EN
   // Blocking the write keeps r_mem[0] at zero, so the read paths need no special case.
   assign w_we_eff = bus.we && (bus.waddr != '0);
`else
   assign w_we_eff = bus.we;
`endif

   assign w_wr_word = WIDTH'(lane_merge(64'(r_mem[bus.waddr]), 64'(bus.wdata), 8'(bus.wstrb)));
   assign w_mem_a   = r_mem[bus.raddr_a];
   assign w_mem_b   = r_mem[bus.raddr_b];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || bus.clr) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_we_eff) begin
         r_mem[bus.waddr] <= w_wr_word;
      end
   end

   regfile_rd_port #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_rd_a (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (bus.clr),
      .i_re       (bus.re_a),
      .i_raddr    (bus.raddr_a),
      .i_mem_data (w_mem_a),
      .i_we       (w_we_eff),
      .i_waddr    (bus.waddr),
      .i_wdata    (bus.wdata),
      .i_wstrb    (bus.wstrb),
      .o_rdata    (bus.rdata_a),
      .o_rvalid   (bus.rvalid_a)
   );

   regfile_rd_port #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_rd_b (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (bus.clr),
      .i_re       (bus.re_b),
      .i_raddr    (bus.raddr_b),
      .i_mem_data (w_mem_b),
      .i_we       (w_we_eff),
      .i_waddr    (bus.waddr),
      .i_wdata    (bus.wdata),
      .i_wstrb    (bus.wstrb),
      .o_rdata    (bus.rdata_b),
      .o_rvalid   (bus.rvalid_b)
   );

endmodule
